dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of data_mem (cache-backed data memory).
- Shares data_mem between requester 0 (CPU load/store unit) and requester 1 (debug/DMA port).
- Issues a single-cycle memread/memwrite strobe and holds addr/data/mask stable while data_mem stalls.
- Returns the read value with a done pulse, and rejects illegal or misaligned accesses without touching memory.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles with mem_clk_stall high before the access is aborted with an error.
- CHECK_ALIGN, 1: 1 enables the misalignment check; 0 passes any address through.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- r0_req, r1_req  in  1  access request; held until the matching gnt.
- r0_we, r1_we  in  1  1 = write, 0 = read.
- r0_addr, r1_addr  in  32  byte address.
- r0_wdata, r1_wdata  in  32  write data.
- r0_mask, r1_mask  in  4  sign_mask encoding: [2:0] size 001 = byte, 011 = half, 111 = word; [3] = sign-extend (reads only).
- r0_gnt, r1_gnt  out  1  one-cycle pulse: request accepted, inputs captured.
- r0_done, r1_done  out  1  one-cycle completion pulse.
- r0_rdata, r1_rdata  out  32  read result; valid while done is high, then held.
- r0_err, r1_err  out  1  qualifies done: illegal mask, misaligned address, or timeout.
- mem_addr  out  32  to data_mem addr.
- mem_write_data  out  32  to data_mem write_data.
- mem_memwrite, mem_memread  out  1  to data_mem; single-cycle strobes.
- mem_sign_mask  out  4  to data_mem sign_mask.
- mem_read_data  in  32  from data_mem read_data.
- mem_clk_stall  in  1  from data_mem clk_stall; high while the access is in progress.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State forced to IDLE; round-robin pointer set to favour r0.
  - All gnt/done/err/strobes/busy = 0; mem_addr, mem_write_data, rdata = 0; mem_sign_mask = 0.
  - Reset mid-transaction drops the strobes immediately and discards the transaction; no done is produced.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, plus IDLE -> RESP for rejected requests.
- IDLE, arbitration:
  - If any req is high at an edge, the winner is chosen by round-robin: on simultaneous requests the port not served last wins; a single request wins outright.
  - Winner's addr/we/wdata/mask are captured into the mem_* registers; gnt is asserted for the following cycle.
  - Pointer updates to the winner.
- Legality check (at capture):
  - mask[2:0] must be 001, 011 or 111; mask[3]=1 with we=1 is illegal.
  - If CHECK_ALIGN=1: half requires addr[0]=0; word requires addr[1:0]=00.
  - Illegal -> next state RESP with err=1 and rdata=0; no strobe is issued.
- ISSUE (1 cycle): exactly one of mem_memread/mem_memwrite = 1 and gnt = 1; the wait counter is cleared.
- WAIT:
  - Strobes = 0; mem_addr/mem_write_data/mem_sign_mask held stable; counter increments each cycle.
  - Exits at the first edge where mem_clk_stall=0 (minimum 1 WAIT cycle). For reads, mem_read_data is latched into the winner's rdata at that edge.
  - If the counter reaches TIMEOUT_CYCLES with mem_clk_stall still high -> RESP with err=1, rdata=0.
- RESP (1 cycle): winner's done = 1; err as determined; the other port's outputs are unchanged.
- Write completion: rdata unchanged, err=0.
- Latency: req sampled at edge t -> gnt/strobe in cycle t+1 -> done in cycle t+3+S, where S = WAIT cycles beyond the first. Minimum 4 cycles between successive grants.
- A request arriving while busy is held pending and arbitrated on return to IDLE.
- A req still high in the RESP cycle is treated as a new request.
- The done/err pulses of the two ports are never high in the same cycle.

Test Plan:
- Reset with rst_n=0 during WAIT of an r0 read:
  - -> memread/memwrite and busy fall immediately, no r0_done; after release, state is IDLE.
- r0 write byte (addr=0x400, wdata=0xAAA, mask=0001), then r0 signed-byte read (mask=1001), with data_mem stalling 5 cycles:
  - -> single memwrite pulse; addr held through the stall; read gives r0_rdata=0xFFFFFFAA, err=0.
  - Unsigned read (mask=0001) -> 0x000000AA.
- r0 and r1 assert req on the same edge after reset (r0 word read at 0x40, r1 half write at 0x100):
  - -> r0 granted first, r1 granted only after r0_done.
  - Next simultaneous pair -> r1 first.
- r1 word read at 0x102 (misaligned):
  - -> r1_gnt, then r1_done with r1_err=1 and rdata=0; memread never asserted.
  - Repeat with mask=0101 -> same error; with mask=1111 on a write -> same error.
- TIMEOUT_CYCLES=8 with mem_clk_stall tied high:
  - -> done+err exactly 8 WAIT cycles after ISSUE; busy low the following cycle.
- r0 word write 0xAAAAAAAA at 0x40, then word read:
  - -> r0_rdata=0xAAAAAAAA.
  - r1_rdata is unchanged throughout and r1_done stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of data_mem.
// Captures the winning request, issues one strobe, waits out the stall and returns done/err/rdata.
module dmem_arbiter #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter bit CHECK_ALIGN    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [31:0] r0_addr,
   input  logic [31:0] r0_wdata,
   input  logic [3:0]  r0_mask,
   output logic        r0_gnt,
   output logic        r0_done,
   output logic [31:0] r0_rdata,
   output logic        r0_err,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [31:0] r1_addr,
   input  logic [31:0] r1_wdata,
   input  logic [3:0]  r1_mask,
   output logic        r1_gnt,
   output logic        r1_done,
   output logic [31:0] r1_rdata,
   output logic        r1_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_write_data,
   output logic        mem_memwrite,
   output logic        mem_memread,
   output logic [3:0]  mem_sign_mask,
   input  logic [31:0] mem_read_data,
   input  logic        mem_clk_stall,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic          own_q, own_d;
   logic          we_q, we_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    mask_q, mask_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          busy_q, busy_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [1:0]    done_q, done_d;
   logic [1:0]    err_q, err_d;
   logic [31:0]   rdata_q [2];
   logic [31:0]   rdata_d [2];

   logic          win;
   logic          sel_we;
   logic [31:0]   sel_addr;
   logic [31:0]   sel_wdata;
   logic [3:0]    sel_mask;

   // Size must be byte/half/word, sign-extend is read-only, and halves/words must be naturally aligned.
   function automatic logic access_ok(input logic we, input logic [31:0] addr, input logic [3:0] mask);
      logic ok;
      ok = 1'b0;
      case (mask[2:0])
         3'b001:  ok = 1'b1;
         3'b011:  ok = !CHECK_ALIGN || (addr[0] == 1'b0);
         3'b111:  ok = !CHECK_ALIGN || (addr[1:0] == 2'b00);
         default: ok = 1'b0;
      endcase
      if (mask[3] && we) begin
         ok = 1'b0;
      end else begin
         ok = ok;
      end
      return ok;
   endfunction

   // Round-robin pick: on a tie the port not served last wins.
   always_comb begin
      win = 1'b0;
      if (r0_req && r1_req) begin
         win = ~last_q;
      end else begin
         win = r1_req;
      end
      sel_we    = win ? r1_we    : r0_we;
      sel_addr  = win ? r1_addr  : r0_addr;
      sel_wdata = win ? r1_wdata : r0_wdata;
      sel_mask  = win ? r1_mask  : r0_mask;
   end

   // Next-state and registered-output logic for the access sequencer.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      own_d   = own_q;
      we_d    = we_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      gnt_d   = 2'b00;
      done_d  = 2'b00;
      err_d   = 2'b00;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (r0_req || r1_req) begin
               own_d      = win;
               last_d     = win;
               we_d       = sel_we;
               addr_d     = sel_addr;
               wdata_d    = sel_wdata;
               mask_d     = sel_mask;
               gnt_d[win] = 1'b1;
               if (access_ok(sel_we, sel_addr, sel_mask)) begin
                  state_d = S_ISSUE;
                  rd_d    = ~sel_we;
                  wr_d    = sel_we;
               end else begin
                  // Rejected: skip memory entirely and answer in the grant cycle.
                  state_d      = S_RESP;
                  done_d[win]  = 1'b1;
                  err_d[win]   = 1'b1;
                  rdata_d[win] = 32'h0000_0000;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            cnt_d   = {CW{1'b0}};
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!mem_clk_stall) begin
               state_d        = S_RESP;
               done_d[own_q]  = 1'b1;
               if (!we_q) begin
                  rdata_d[own_q] = mem_read_data;
               end else begin
                  rdata_d[own_q] = rdata_q[own_q];
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d        = S_RESP;
               done_d[own_q]  = 1'b1;
               err_d[own_q]   = 1'b1;
               rdata_d[own_q] = 32'h0000_0000;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset discards any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         last_q     <= 1'b1;
         own_q      <= 1'b0;
         we_q       <= 1'b0;
         cnt_q      <= {CW{1'b0}};
         addr_q     <= 32'h0000_0000;
         wdata_q    <= 32'h0000_0000;
         mask_q     <= 4'h0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         busy_q     <= 1'b0;
         gnt_q      <= 2'b00;
         done_q     <= 2'b00;
         err_q      <= 2'b00;
         rdata_q[0] <= 32'h0000_0000;
         rdata_q[1] <= 32'h0000_0000;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         own_q      <= own_d;
         we_q       <= we_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         busy_q     <= busy_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rdata_q[0] <= rdata_d[0];
         rdata_q[1] <= rdata_d[1];
      end
   end

   assign r0_gnt         = gnt_q[0];
   assign r1_gnt         = gnt_q[1];
   assign r0_done        = done_q[0];
   assign r1_done        = done_q[1];
   assign r0_err         = err_q[0];
   assign r1_err         = err_q[1];
   assign r0_rdata       = rdata_q[0];
   assign r1_rdata       = rdata_q[1];
   assign mem_addr       = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_sign_mask  = mask_q;
   assign mem_memread    = rd_q;
   assign mem_memwrite   = wr_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: emulated data_mem with programmable stall, byte-level reference memory,
// directed scenarios followed by randomized single and paired requests.
module tb_dmem_arbiter;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [1:0]  we_s = 2'b00;
   logic [31:0] addr_s [2] = '{32'h0, 32'h0};
   logic [31:0] wdata_s [2] = '{32'h0, 32'h0};
   logic [3:0]  mask_s [2] = '{4'h0, 4'h0};
   logic [1:0]  gnt, done, err;
   logic [31:0] rdata [2];
   logic [31:0] mem_addr, mem_write_data, mem_read_data = 32'h0;
   logic        mem_memwrite, mem_memread, mem_clk_stall = 1'b0, busy;
   logic [3:0]  mem_sign_mask;

   int total = 0;
   int bad = 0;

   dmem_arbiter #(.TIMEOUT_CYCLES(TMO), .CHECK_ALIGN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(req[0]), .r0_we(we_s[0]), .r0_addr(addr_s[0]), .r0_wdata(wdata_s[0]), .r0_mask(mask_s[0]),
      .r0_gnt(gnt[0]), .r0_done(done[0]), .r0_rdata(rdata[0]), .r0_err(err[0]),
      .r1_req(req[1]), .r1_we(we_s[1]), .r1_addr(addr_s[1]), .r1_wdata(wdata_s[1]), .r1_mask(mask_s[1]),
      .r1_gnt(gnt[1]), .r1_done(done[1]), .r1_rdata(rdata[1]), .r1_err(err[1]),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
      .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
      .mem_clk_stall(mem_clk_stall), .busy(busy)
   );

   always #5 clk = ~clk;

   // data_mem emulation and reference memory (byte arrays, little-endian)
   bit [7:0]    dm [4096];
   bit [7:0]    em [4096];
   int          rem = 0, rd_cnt = 0, wr_cnt = 0, mv_cnt = 0;
   int          stall_len = 0;
   bit          tie_high = 1'b0;
   bit          in_acc = 1'b0;
   logic [31:0] cap_addr, cap_wd;
   logic [3:0]  cap_mask;

   function automatic logic [31:0] ext(input logic [31:0] raw, input logic [3:0] m);
      case (m[2:0])
         3'b001:  return m[3] ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
         3'b011:  return m[3] ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   function automatic bit is_legal(input bit w, input logic [31:0] a, input logic [3:0] m);
      bit sz_ok, al_ok;
      sz_ok = (m[2:0] == 3'b001) || (m[2:0] == 3'b011) || (m[2:0] == 3'b111);
      al_ok = (m[2:0] == 3'b011) ? (a[0] == 1'b0) : (m[2:0] == 3'b111) ? (a[1:0] == 2'b00) : 1'b1;
      return sz_ok && al_ok && !(m[3] && w);
   endfunction

   always @(negedge clk) begin
      logic [11:0] ix;
      ix = mem_addr[11:0];
      if (!rst_n) begin
         rem = 0;
         in_acc = 1'b0;
         mem_clk_stall = 1'b0;
      end else if (mem_memread || mem_memwrite) begin
         in_acc = 1'b1;
         cap_addr = mem_addr;
         cap_wd = mem_write_data;
         cap_mask = mem_sign_mask;
         if (mem_memwrite) begin
            wr_cnt++;
            dm[ix] = mem_write_data[7:0];
            if (mem_sign_mask[1]) dm[ix + 12'd1] = mem_write_data[15:8];
            if (mem_sign_mask[2]) begin
               dm[ix + 12'd2] = mem_write_data[23:16];
               dm[ix + 12'd3] = mem_write_data[31:24];
            end
         end
         if (mem_memread) begin
            rd_cnt++;
            mem_read_data = ext({dm[ix + 12'd3], dm[ix + 12'd2], dm[ix + 12'd1], dm[ix]}, mem_sign_mask);
         end
         rem = stall_len;
         mem_clk_stall = 1'b1;
      end else if (in_acc) begin
         if (mem_addr !== cap_addr || mem_write_data !== cap_wd || mem_sign_mask !== cap_mask) mv_cnt++;
         if (tie_high) begin
            mem_clk_stall = 1'b1;
         end else if (rem > 0) begin
            rem--;
            mem_clk_stall = 1'b1;
         end else begin
            mem_clk_stall = 1'b0;
            in_acc = 1'b0;
         end
      end
   end

   int          last_served = 1;
   logic [31:0] prev_rd [2] = '{32'h0, 32'h0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One request per enabled port, raised on the same edge; model predicts order, latency and results.
   task automatic run_set(input bit [1:0] en, input bit [1:0] w,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [3:0] m0, input logic [3:0] m1,
                          input int s, input bit tmo);
      logic [31:0] aa [2], dd [2], er [2], ro [2], keep [2];
      logic [3:0]  mm [2];
      bit          ee [2], eo [2];
      int          lat [2], gc [2], dc [2], gn [2], dn [2];
      int          first, second, exp_rd, exp_wr, rd0, wr0, mv0, collide, stray, chg, cyc;
      aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1; mm[0] = m0; mm[1] = m1;
      first = (en == 2'b11) ? ((last_served == 0) ? 1 : 0) : (en[1] ? 1 : 0);
      second = 1 - first;
      stall_len = s;
      tie_high = tmo;
      exp_rd = 0; exp_wr = 0;
      for (int k = 0; k < 2; k++) begin
         int p;
         logic [11:0] ix;
         p = (k == 0) ? first : second;
         ix = aa[p][11:0];
         ee[p] = 1'b0; er[p] = prev_rd[p]; lat[p] = 0;
         if (en[p]) begin
            if (!is_legal(w[p], aa[p], mm[p])) begin
               ee[p] = 1'b1; er[p] = 32'h0; lat[p] = 0;
            end else if (tmo) begin
               ee[p] = 1'b1; er[p] = 32'h0; lat[p] = TMO + 1;
               if (w[p]) exp_wr++; else exp_rd++;
            end else begin
               lat[p] = 2 + s;
               if (w[p]) begin
                  exp_wr++;
                  em[ix] = dd[p][7:0];
                  if (mm[p][2:0] != 3'b001) em[ix + 12'd1] = dd[p][15:8];
                  if (mm[p][2:0] == 3'b111) begin
                     em[ix + 12'd2] = dd[p][23:16];
                     em[ix + 12'd3] = dd[p][31:24];
                  end
               end else begin
                  exp_rd++;
                  er[p] = ext({em[ix + 12'd3], em[ix + 12'd2], em[ix + 12'd1], em[ix]}, mm[p]);
               end
            end
         end
      end
      @(negedge clk); #1;
      rd0 = rd_cnt; wr0 = wr_cnt; mv0 = mv_cnt;
      keep[0] = prev_rd[0]; keep[1] = prev_rd[1];
      for (int p = 0; p < 2; p++) begin
         gc[p] = -1; dc[p] = -1; gn[p] = 0; dn[p] = 0; eo[p] = 1'b0; ro[p] = 32'h0;
         if (en[p]) begin
            req[p] = 1'b1; we_s[p] = w[p]; addr_s[p] = aa[p]; wdata_s[p] = dd[p]; mask_s[p] = mm[p];
         end
      end
      collide = 0; stray = 0; chg = 0; cyc = 0;
      while (((en[0] && dn[0] == 0) || (en[1] && dn[1] == 0)) && cyc < 120) begin
         @(negedge clk); #1;
         cyc++;
         for (int p = 0; p < 2; p++) begin
            if (gnt[p]) begin gn[p]++; gc[p] = cyc; req[p] = 1'b0; end
            if (done[p]) begin dn[p]++; dc[p] = cyc; eo[p] = err[p]; ro[p] = rdata[p]; end
            else if (err[p]) stray++;
            if (!en[p] && rdata[p] !== keep[p]) chg++;
         end
         if (done == 2'b11) collide++;
      end
      @(negedge clk); #1;
      chk("busy_after", busy, 1'b0);
      chk("done_after", done, 2'b00);
      for (int p = 0; p < 2; p++) begin
         if (en[p]) begin
            chk($sformatf("gnt_cnt%0d", p), gn[p], 1);
            chk($sformatf("done_cnt%0d", p), dn[p], 1);
            chk($sformatf("lat%0d", p), dc[p] - gc[p], lat[p]);
            chk($sformatf("err%0d", p), eo[p], ee[p]);
            chk($sformatf("rdata%0d", p), ro[p], er[p]);
            prev_rd[p] = er[p];
         end else begin
            chk($sformatf("idle_done%0d", p), dn[p] + gn[p], 0);
            chk($sformatf("idle_rdata%0d", p), chg, 0);
         end
      end
      chk("first_gnt_cycle", gc[first], 1);
      if (en == 2'b11) chk("second_gnt_cycle", gc[second], dc[first] + 2);
      chk("rd_strobes", rd_cnt - rd0, exp_rd);
      chk("wr_strobes", wr_cnt - wr0, exp_wr);
      chk("hold_stable", mv_cnt - mv0, 0);
      chk("done_collide", collide, 0);
      chk("stray_err", stray, 0);
      last_served = (en == 2'b11) ? second : first;
      tie_high = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst_n = 1'b0;
      req = 2'b00;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      last_served = 1;
      prev_rd[0] = 32'h0;
      prev_rd[1] = 32'h0;
   endtask

   initial begin
      logic [3:0] mtab [8];
      int n, dcount;
      mtab[0] = 4'b0001; mtab[1] = 4'b0011; mtab[2] = 4'b0111; mtab[3] = 4'b1001;
      mtab[4] = 4'b1011; mtab[5] = 4'b1111; mtab[6] = 4'b0101; mtab[7] = 4'b0000;

      // reset values
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ctl", {gnt, done, err, mem_memread, mem_memwrite, busy}, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_write_data, 32'h0);
      chk("rst_mask", mem_sign_mask, 32'h0);
      chk("rst_rdata0", rdata[0], 32'h0);
      chk("rst_rdata1", rdata[1], 32'h0);
      rst_n = 1'b1;

      // reset while an r0 read is stalled in WAIT
      @(negedge clk); #1;
      stall_len = 5;
      req[0] = 1'b1; we_s[0] = 1'b0; addr_s[0] = 32'h400; mask_s[0] = 4'b0111;
      n = 0;
      while (!gnt[0] && n < 10) begin @(negedge clk); #1; n++; end
      chk("rst_gnt", gnt[0], 1'b1);
      chk("rst_issue_rd", mem_memread, 1'b1);
      req[0] = 1'b0;
      @(negedge clk); #1;
      chk("rst_wait_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("rst_async", {mem_memread, mem_memwrite, busy, done}, 32'h0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      dcount = 0;
      repeat (6) begin @(negedge clk); #1; dcount += int'(done[0]) + int'(done[1]); end
      chk("rst_no_done", dcount, 0);
      chk("rst_idle", busy, 1'b0);

      // byte write, signed and unsigned byte reads with a 5-cycle stall
      run_set(2'b01, 2'b01, 32'h400, 32'h0, 32'hAAA, 32'h0, 4'b0001, 4'h0, 5, 1'b0);
      run_set(2'b01, 2'b00, 32'h400, 32'h0, 32'h0, 32'h0, 4'b1001, 4'h0, 5, 1'b0);
      chk("sbyte_read", rdata[0], 32'hFFFF_FFAA);
      run_set(2'b01, 2'b00, 32'h400, 32'h0, 32'h0, 32'h0, 4'b0001, 4'h0, 5, 1'b0);
      chk("ubyte_read", rdata[0], 32'h0000_00AA);

      // simultaneous requests after reset: r0 first; then r1 wins once r0 was served last
      do_reset();
      run_set(2'b11, 2'b10, 32'h40, 32'h100, 32'h0, 32'h1234_BEEF, 4'b0111, 4'b0011, 1, 1'b0);
      run_set(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 4'b0111, 4'h0, 0, 1'b0);
      run_set(2'b11, 2'b01, 32'h44, 32'h100, 32'h5555_0001, 32'h0, 4'b0111, 4'b1011, 2, 1'b0);
      chk("pair2_r1_half", rdata[1], 32'hFFFF_BEEF);

      // rejected requests on r1
      run_set(2'b10, 2'b00, 32'h0, 32'h102, 32'h0, 32'h0, 4'h0, 4'b0111, 0, 1'b0);
      chk("misalign_rdata", rdata[1], 32'h0);
      run_set(2'b10, 2'b00, 32'h0, 32'h100, 32'h0, 32'h0, 4'h0, 4'b0011, 0, 1'b0);
      run_set(2'b10, 2'b00, 32'h0, 32'h100, 32'h0, 32'h0, 4'h0, 4'b0101, 0, 1'b0);
      run_set(2'b10, 2'b10, 32'h0, 32'h100, 32'h0, 32'h1, 4'h0, 4'b1111, 0, 1'b0);
      run_set(2'b10, 2'b00, 32'h0, 32'h101, 32'h0, 32'h0, 4'h0, 4'b0011, 0, 1'b0);

      // timeout with stall held high
      run_set(2'b01, 2'b00, 32'h80, 32'h0, 32'h0, 32'h0, 4'b0111, 4'h0, 0, 1'b1);
      repeat (3) @(negedge clk);

      // word write then read back
      run_set(2'b01, 2'b01, 32'h40, 32'h0, 32'hAAAA_AAAA, 32'h0, 4'b0111, 4'h0, 1, 1'b0);
      run_set(2'b01, 2'b00, 32'h40, 32'h0, 32'h0, 32'h0, 4'b0111, 4'h0, 3, 1'b0);
      chk("word_rb", rdata[0], 32'hAAAA_AAAA);

      // randomized single and paired traffic
      for (int i = 0; i < 40; i++) begin
         bit [1:0] en, w;
         en = 2'($urandom_range(1, 3));
         w = 2'($urandom_range(0, 3));
         run_set(en, w, 32'h200 + 32'($urandom_range(0, 511)), 32'h200 + 32'($urandom_range(0, 511)),
                 $urandom, $urandom, mtab[$urandom_range(0, 7)], mtab[$urandom_range(0, 7)],
                 $urandom_range(0, 3), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
